conway_axil_reg_slave: RTL and testbench
========================================

# conway_axil_reg_slave

AXI4-Lite responder exposing four 32-bit read/write registers for the Game of Life controller. Sits between the AXI interconnect (driven by the system master or the lite master BFM in simulation) and the life engine: decodes single-beat writes/reads, applies byte strobes, returns OKAY/SLVERR responses, and presents register contents plus per-register write strobes to downstream logic.

## Interface
- DATA_WIDTH, 32, AXI data width; fixed at 32, byte lanes = 4
- ADDR_WIDTH, 6, AXI address width; must be ≥4; word index = ADDR[ADDR_WIDTH-1:2]
- RESET_VAL0..RESET_VAL3, 32'h0, reset value of register 0..3

- ACLK  in  1  single clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- reg0_o..reg3_o  out  32  current register contents
- wr_pulse_o  out  4  one-cycle pulse, bit i set on the cycle after register i is written

## Operation
- Register map: word 0..3 at byte offsets 0x0, 0x4, 0x8, 0xC; all fully read/write, no side effects on read.
- Write path, states W_IDLE / W_RESP:
  - W_IDLE: AWREADY=1 while AW not yet captured; WREADY=1 while W not yet captured. AW and W accepted independently, in any order, each latched once.
  - Commit on the edge where both are held (or handshaking that edge): each byte k with WSTRB[k]=1 updates; WSTRB=0 leaves register unchanged but still responds. Go to W_RESP, BVALID=1.
  - W_RESP: AWREADY=WREADY=0; hold BVALID/BRESP until BREADY; on BVALID&BREADY return to W_IDLE, clear latches.
- Read path, states R_IDLE / R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY capture RDATA from register (pre-edge value), RRESP, go R_DATA, RVALID=1.
  - R_DATA: ARREADY=0; RDATA/RRESP stable until RVALID&RREADY, then R_IDLE.
- Read and write paths independent; same-edge read and write to same register returns old value.
- Unmapped word index (≥4): no register update, no wr_pulse_o; RDATA=0; response per Configuration.
- Address bits [1:0] ignored.

## Timing
- Reset (async assert, outputs valid immediately): AWREADY=WREADY=ARREADY=0 during reset, =1 on first edge after release; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; regs=RESET_VALi; wr_pulse_o=0.
- Write latency: last of AW/W handshakes at edge N → register and BVALID updated at N; wr_pulse_o high for cycle N+1 only.
- Read latency: AR handshake at edge N → RVALID/RDATA valid after N.
- Back-to-back: max one write per 2 cycles with BREADY held high; one read per 2 cycles with RREADY held high.
- Reset mid-transaction aborts it: latches cleared, no partial register update, no response issued.

## Configuration
- CONWAY_AXIL_SLVERR_EN defined: unmapped reads/writes return SLVERR (2'b10).
- Not defined: unmapped accesses return OKAY (2'b00); data ignored/zero as above.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0,0x4,0x8,0xC, read each back -> RDATA matches, BRESP=RRESP=OKAY, wr_pulse_o = 0001,0010,0100,1000 one cycle each.
- Reg1=0xABCD0001, write 0x12345678 WSTRB=4'b0101 -> read 0xAB340078.
- W presented 3 cycles before AW, BREADY low 4 cycles -> single commit, BVALID held 4 cycles, AWREADY/WREADY low throughout W_RESP.
- Read 0x10 (ADDR_WIDTH=6) -> RDATA=0, RRESP=SLVERR with macro, OKAY without; write 0x10 -> no reg changes, no pulse.
- Same-edge write 0x5 to reg2 (was 0x3) and read reg2 -> read returns 0x3; next read 0x5.
- Assert ARESET while BVALID=1 and RVALID=1 -> both drop asynchronously, regs return to RESET_VALi, next transaction completes normally.

Source files
------------

// File: rtl/conway_axil_reg_slave.sv
// AXI4-Lite responder exposing four 32-bit R/W registers and per-register write pulses.
// Define CONWAY_AXIL_SLVERR_EN to answer unmapped word indices with SLVERR instead of OKAY.
module conway_axil_reg_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [31:0] RESET_VAL0 = 32'h0,
    parameter logic [31:0] RESET_VAL1 = 32'h0,
    parameter logic [31:0] RESET_VAL2 = 32'h0,
    parameter logic [31:0] RESET_VAL3 = 32'h0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [DATA_WIDTH-1:0]   reg0_o,
    output logic [DATA_WIDTH-1:0]   reg1_o,
    output logic [DATA_WIDTH-1:0]   reg2_o,
    output logic [DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]              wr_pulse_o
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef CONWAY_AXIL_SLVERR_EN
    localparam logic [1:0]  RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0]  RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [4];
    logic [DATA_WIDTH-1:0] regs_d [4];

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_mapped, rd_mapped;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_strb;
    logic                  unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write path: a latched AW or W beat is merged with the live one so commit can happen on
    // the same edge as whichever handshake arrives last.
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        aw_hs     = S_AXI_AWVALID & awready_q;
        w_hs      = S_AXI_WVALID & wready_q;
        wr_idx    = aw_held_q ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
        wr_data   = w_held_q ? wdata_q : S_AXI_WDATA;
        wr_strb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
        wr_mapped = ((wr_idx >> 2) == '0);

        case (w_state_q)
            W_IDLE: begin
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    if (wr_mapped) begin
                        for (int unsigned k = 0; k < NBYTES; k++) begin
                            if (wr_strb[k]) begin
                                regs_d[wr_idx[1:0]][8*k +: 8] = wr_data[8*k +: 8];
                            end
                        end
                        wr_pulse_d[wr_idx[1:0]] = 1'b1;
                    end
                    bresp_d   = wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awidx_d   = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                        awready_d = 1'b0;
                    end else if (!aw_held_q) begin
                        awready_d = 1'b1;
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                        wready_d = 1'b0;
                    end else if (!w_held_q) begin
                        wready_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path samples the registers before any same-edge write lands.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        ar_hs     = S_AXI_ARVALID & arready_q;
        rd_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];
        rd_mapped = ((rd_idx >> 2) == '0);

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_mapped ? regs_q[rd_idx[1:0]] : '0;
                    rresp_d   = rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            regs_q[0]  <= RESET_VAL0;
            regs_q[1]  <= RESET_VAL1;
            regs_q[2]  <= RESET_VAL2;
            regs_q[3]  <= RESET_VAL3;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg0_o        = regs_q[0];
    assign reg1_o        = regs_q[1];
    assign reg2_o        = regs_q[2];
    assign reg3_o        = regs_q[3];
    assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_conway_axil_reg_slave.sv
// Directed self-checking bench for conway_axil_reg_slave (ADDR_WIDTH=6, non-zero reset values).
module tb_conway_axil_reg_slave;

    localparam logic [31:0] RV0 = 32'hA5A5_0000;
    localparam logic [31:0] RV1 = 32'h0000_1111;
    localparam logic [31:0] RV2 = 32'h0000_0000;
    localparam logic [31:0] RV3 = 32'hFFFF_0000;
`ifdef CONWAY_AXIL_SLVERR_EN
    localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
    logic [3:0]  wr_pulse_o;

    int compared = 0;
    int mismatched = 0;

    always #5 ACLK = ~ACLK;

    conway_axil_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6),
        .RESET_VAL0(RV0),
        .RESET_VAL1(RV1),
        .RESET_VAL2(RV2),
        .RESET_VAL3(RV3)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .wr_pulse_o(wr_pulse_o)
    );

    // Full write with BREADY high; reports pulse right after commit and one cycle later.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse_c,
                             output logic [3:0] pulse_n, output bit ok);
        bit aw_done, w_done, aw_r, w_r;
        int unsigned n;
        ok = 1'b1; aw_done = 1'b0; w_done = 1'b0; n = 0;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_r = S_AXI_AWREADY & S_AXI_AWVALID;
            w_r  = S_AXI_WREADY & S_AXI_WVALID;
            @(posedge ACLK); #1;
            if (aw_r) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_r) begin w_done = 1'b1; S_AXI_WVALID = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        pulse_c = wr_pulse_o;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!aw_done || !w_done || !S_AXI_BVALID) ok = 1'b0;
        resp = S_AXI_BRESP;
        @(posedge ACLK); #1;
        pulse_n = wr_pulse_o;
        if (S_AXI_BVALID) ok = 1'b0;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit done, ar_r;
        int unsigned n;
        ok = 1'b1; done = 1'b0; n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!done && n < 20) begin
            ar_r = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (ar_r) done = 1'b1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done || !S_AXI_RVALID) ok = 1'b0;
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        if (S_AXI_RVALID) ok = 1'b0;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        #1 ARESET = 1'b1;
        #2;
        compared++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin mismatched++; $display("FAIL rst_ready: got %b expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        compared++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin mismatched++; $display("FAIL rst_valid: got %b expected 00", {S_AXI_BVALID, S_AXI_RVALID}); end
        compared++; if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'b0000) begin mismatched++; $display("FAIL rst_resp: got %b expected 0000", {S_AXI_BRESP, S_AXI_RRESP}); end
        compared++; if (S_AXI_RDATA !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h expected 0", S_AXI_RDATA); end
        compared++; if (reg0_o !== RV0) begin mismatched++; $display("FAIL rst_reg0: got %h expected %h", reg0_o, RV0); end
        compared++; if (reg1_o !== RV1) begin mismatched++; $display("FAIL rst_reg1: got %h expected %h", reg1_o, RV1); end
        compared++; if (reg2_o !== RV2) begin mismatched++; $display("FAIL rst_reg2: got %h expected %h", reg2_o, RV2); end
        compared++; if (reg3_o !== RV3) begin mismatched++; $display("FAIL rst_reg3: got %h expected %h", reg3_o, RV3); end
        compared++; if (wr_pulse_o !== 4'h0) begin mismatched++; $display("FAIL rst_pulse: got %b expected 0000", wr_pulse_o); end
        @(posedge ACLK); #1 ARESET = 1'b0;
        compared++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin mismatched++; $display("FAIL rel_ready_before_edge: got %b expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        @(posedge ACLK); #1;
        compared++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin mismatched++; $display("FAIL rel_ready_after_edge: got %b expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    endtask

    task automatic test_write_read();
        logic [31:0] wd [4];
        logic [31:0] regs_now [4];
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [3:0]  pc, pn, exp_p;
        bit ok;
        wd = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int i = 0; i < 4; i++) begin
            exp_p = 4'b0001 << i;
            axi_write(6'(4 * i), wd[i], 4'hF, resp, pc, pn, ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL wr%0d_handshake: got timeout/protocol error expected completion", i); end
            compared++; if (resp !== 2'b00) begin mismatched++; $display("FAIL wr%0d_bresp: got %b expected 00", i, resp); end
            compared++; if (pc !== exp_p) begin mismatched++; $display("FAIL wr%0d_pulse: got %b expected %b", i, pc, exp_p); end
            compared++; if (pn !== 4'h0) begin mismatched++; $display("FAIL wr%0d_pulse_next: got %b expected 0000", i, pn); end
        end
        regs_now = '{reg0_o, reg1_o, reg2_o, reg3_o};
        for (int i = 0; i < 4; i++) begin
            compared++; if (regs_now[i] !== wd[i]) begin mismatched++; $display("FAIL reg%0d_out: got %h expected %h", i, regs_now[i], wd[i]); end
            axi_read(6'(4 * i), rd, resp, ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL rd%0d_handshake: got timeout/protocol error expected completion", i); end
            compared++; if (rd !== wd[i]) begin mismatched++; $display("FAIL rd%0d_data: got %h expected %h", i, rd, wd[i]); end
            compared++; if (resp !== 2'b00) begin mismatched++; $display("FAIL rd%0d_rresp: got %b expected 00", i, resp); end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [3:0]  pc, pn;
        bit ok;
        axi_write(6'h04, 32'h12345678, 4'b0101, resp, pc, pn, ok);
        axi_read(6'h04, rd, resp, ok);
        compared++; if (rd !== 32'hAB340078) begin mismatched++; $display("FAIL strb_0101: got %h expected ab340078", rd); end
        axi_write(6'h04, 32'hFFFFFFFF, 4'b0000, resp, pc, pn, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL strb_0000_resp_missing: got no response expected response"); end
        compared++; if (resp !== 2'b00) begin mismatched++; $display("FAIL strb_0000_bresp: got %b expected 00", resp); end
        compared++; if (reg1_o !== 32'hAB340078) begin mismatched++; $display("FAIL strb_0000_reg: got %h expected ab340078", reg1_o); end
    endtask

    task automatic test_w_before_aw();
        int unsigned pulses;
        pulses = 0;
        S_AXI_AWADDR = 6'h0C;
        S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        if (wr_pulse_o[3]) pulses++;
        compared++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b10) begin mismatched++; $display("FAIL wfirst_ready: got %b expected 10", {S_AXI_AWREADY, S_AXI_WREADY}); end
        repeat (2) begin @(posedge ACLK); #1; if (wr_pulse_o[3]) pulses++; end
        compared++; if (S_AXI_BVALID !== 1'b0) begin mismatched++; $display("FAIL wfirst_no_early_b: got %b expected 0", S_AXI_BVALID); end
        compared++; if (reg3_o !== 32'hBEEF0011) begin mismatched++; $display("FAIL wfirst_no_early_commit: got %h expected beef0011", reg3_o); end
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        if (wr_pulse_o[3]) pulses++;
        compared++; if (S_AXI_BVALID !== 1'b1) begin mismatched++; $display("FAIL wfirst_bvalid: got %b expected 1", S_AXI_BVALID); end
        compared++; if (reg3_o !== 32'h13579BDF) begin mismatched++; $display("FAIL wfirst_commit: got %h expected 13579bdf", reg3_o); end
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            if (wr_pulse_o[3]) pulses++;
            compared++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin mismatched++; $display("FAIL wfirst_hold%0d: got bvalid/awready/wready %b expected 100", i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        compared++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin mismatched++; $display("FAIL wfirst_release: got %b expected 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL wfirst_single_pulse: got %0d expected 1", pulses); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [3:0]  pc, pn;
        bit ok;
        axi_read(6'h10, rd, resp, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL unm_rd_handshake: got timeout expected completion"); end
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL unm_rdata: got %h expected 0", rd); end
        compared++; if (resp !== EXP_UNMAPPED) begin mismatched++; $display("FAIL unm_rresp: got %b expected %b", resp, EXP_UNMAPPED); end
        axi_write(6'h10, 32'hFFFFFFFF, 4'hF, resp, pc, pn, ok);
        compared++; if (resp !== EXP_UNMAPPED) begin mismatched++; $display("FAIL unm_bresp: got %b expected %b", resp, EXP_UNMAPPED); end
        compared++; if ({pc, pn} !== 8'h00) begin mismatched++; $display("FAIL unm_pulse: got %b expected 00000000", {pc, pn}); end
        compared++; if ({reg0_o, reg1_o, reg2_o, reg3_o} !== {32'h0101FFFF, 32'hAB340078, 32'hDEAD0011, 32'h13579BDF}) begin mismatched++; $display("FAIL unm_regs: got %h %h %h %h expected 0101ffff ab340078 dead0011 13579bdf", reg0_o, reg1_o, reg2_o, reg3_o); end
        axi_read(6'h07, rd, resp, ok);
        compared++; if (rd !== 32'hAB340078) begin mismatched++; $display("FAIL addr_lsb_ignored: got %h expected ab340078", rd); end
    endtask

    task automatic test_same_edge();
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [3:0]  pc, pn;
        bit ok;
        axi_write(6'h08, 32'h3, 4'hF, resp, pc, pn, ok);
        S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        compared++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin mismatched++; $display("FAIL same_valids: got %b expected 11", {S_AXI_BVALID, S_AXI_RVALID}); end
        compared++; if (S_AXI_RDATA !== 32'h3) begin mismatched++; $display("FAIL same_old_value: got %h expected 3", S_AXI_RDATA); end
        compared++; if (reg2_o !== 32'h5) begin mismatched++; $display("FAIL same_reg_updated: got %h expected 5", reg2_o); end
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(6'h08, rd, resp, ok);
        compared++; if (rd !== 32'h5) begin mismatched++; $display("FAIL same_next_read: got %h expected 5", rd); end
    endtask

    task automatic test_back_to_back();
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = 6'h04;
        compared++; if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA} !== {2'b10, 32'h0101FFFF}) begin mismatched++; $display("FAIL b2b_rd0: got rvalid/arready %b data %h expected 10 0101ffff", {S_AXI_RVALID, S_AXI_ARREADY}, S_AXI_RDATA); end
        @(posedge ACLK); #1;
        compared++; if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin mismatched++; $display("FAIL b2b_rd_gap: got %b expected 01", {S_AXI_RVALID, S_AXI_ARREADY}); end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        compared++; if ({S_AXI_RVALID, S_AXI_RDATA} !== {1'b1, 32'hAB340078}) begin mismatched++; $display("FAIL b2b_rd1: got rvalid %b data %h expected 1 ab340078", S_AXI_RVALID, S_AXI_RDATA); end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        compared++; if (S_AXI_RVALID !== 1'b0) begin mismatched++; $display("FAIL b2b_rd_done: got %b expected 0", S_AXI_RVALID); end
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h33334444;
        compared++; if ({S_AXI_BVALID, S_AXI_AWREADY, reg0_o} !== {2'b10, 32'h11112222}) begin mismatched++; $display("FAIL b2b_wr0: got bvalid/awready %b reg0 %h expected 10 11112222", {S_AXI_BVALID, S_AXI_AWREADY}, reg0_o); end
        @(posedge ACLK); #1;
        compared++; if ({S_AXI_BVALID, S_AXI_AWREADY, reg3_o} !== {2'b01, 32'h13579BDF}) begin mismatched++; $display("FAIL b2b_wr_gap: got bvalid/awready %b reg3 %h expected 01 13579bdf", {S_AXI_BVALID, S_AXI_AWREADY}, reg3_o); end
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        compared++; if ({S_AXI_BVALID, reg3_o} !== {1'b1, 32'h33334444}) begin mismatched++; $display("FAIL b2b_wr1: got bvalid %b reg3 %h expected 1 33334444", S_AXI_BVALID, reg3_o); end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        compared++; if (S_AXI_BVALID !== 1'b0) begin mismatched++; $display("FAIL b2b_wr_done: got %b expected 0", S_AXI_BVALID); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  resp;
        int unsigned n;
        bit ok;
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h77778888; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 10) begin @(posedge ACLK); #1; n++; end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 10) begin @(posedge ACLK); #1; n++; end
        S_AXI_ARVALID = 1'b0;
        compared++; if ({S_AXI_BVALID, S_AXI_RVALID, reg0_o} !== {2'b11, 32'h77778888}) begin mismatched++; $display("FAIL rmid_setup: got b/r valid %b reg0 %h expected 11 77778888", {S_AXI_BVALID, S_AXI_RVALID}, reg0_o); end
        #3 ARESET = 1'b1;
        #1;
        compared++; if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY} !== 4'b0000) begin mismatched++; $display("FAIL rmid_async_drop: got %b expected 0000", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}); end
        compared++; if ({reg0_o, reg1_o, reg2_o, reg3_o} !== {RV0, RV1, RV2, RV3}) begin mismatched++; $display("FAIL rmid_regs: got %h %h %h %h expected reset values", reg0_o, reg1_o, reg2_o, reg3_o); end
        compared++; if (S_AXI_RDATA !== 32'h0) begin mismatched++; $display("FAIL rmid_rdata: got %h expected 0", S_AXI_RDATA); end
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        // Latch a lone W beat, reset, then confirm AW alone does not commit it.
        S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        #3 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        compared++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin mismatched++; $display("FAIL rmid_latch_cleared: got %b expected 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
        S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        repeat (2) begin @(posedge ACLK); #1; end
        compared++; if ({S_AXI_BVALID, reg1_o} !== {1'b0, RV1}) begin mismatched++; $display("FAIL rmid_no_stale_commit: got bvalid %b reg1 %h expected 0 %h", S_AXI_BVALID, reg1_o, RV1); end
        S_AXI_WDATA = 32'h600DD00D; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        compared++; if ({S_AXI_BVALID, S_AXI_BRESP, reg1_o, wr_pulse_o} !== {3'b100, 32'h600DD00D, 4'b0010}) begin mismatched++; $display("FAIL rmid_next_write: got bvalid %b bresp %b reg1 %h pulse %b expected 1 00 600dd00d 0010", S_AXI_BVALID, S_AXI_BRESP, reg1_o, wr_pulse_o); end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        axi_read(6'h04, rd, resp, ok);
        compared++; if ({ok, rd, resp} !== {1'b1, 32'h600DD00D, 2'b00}) begin mismatched++; $display("FAIL rmid_next_read: got ok %b data %h resp %b expected 1 600dd00d 00", ok, rd, resp); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_w_before_aw();
        test_unmapped();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
